// File: rtl/board_pkg.sv
// board_pkg: shared timing helpers for board input conditioning and game timing
package board_pkg;
  function automatic int db_cycles(input int clk_mhz, input int debounce_us);
    return clk_mhz * debounce_us;
  endfunction
  // Counter must hold DB_CYCLES without wrapping; a floor of 1 bit keeps bad configs elaborating to the error check
  function automatic int cnt_width(input int db);
    return (db < 1) ? 1 : $clog2(db + 1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus stable-time debouncer for one push-button
// Ports: clk_i clock; rst_i active-high reset, async assert; key_i raw level;
//        level_o debounced level (1 = pressed); press_o / release_o one-cycle edge pulses.
module key_debounce
  import board_pkg::*;
#(
  parameter int DB_CYCLES      = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = cnt_width(DB_CYCLES);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, press_q, press_d, release_q, release_d;
  logic          pressed, differ, done;
  always_comb begin
    pressed   = sync_q[1] ^ KEY_ACTIVE_LOW;
    differ    = pressed != level_q;
    done      = differ && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d     = (differ && !done) ? cnt_q + 1'b1 : '0;
    level_d   = done ? pressed : level_q;
    press_d   = done && pressed;
    release_d = done && !pressed;
  end
  // Sync flops reset to the released raw level so a held key is seen as a fresh press after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= {2{KEY_ACTIVE_LOW}};
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: reset synchroniser and per-key debouncers for board push-buttons
// Ports: clk_i system clock; rst_n_i async active-low board reset; keys_i raw buttons;
//        rst_o core reset (async assert, sync release); keys_o debounced levels;
//        key_press_o / key_release_o one-cycle edge pulses per key.
module board_input_conditioner
  import board_pkg::*;
#(
  parameter int CLK_MHZ        = 50,
  parameter int N_KEYS         = 2,
  parameter int DEBOUNCE_US    = 10000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int RST_STAGES     = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_KEYS-1:0] keys_i,
  output logic              rst_o,
  output logic [N_KEYS-1:0] keys_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o
);
  localparam int DB_CYCLES = db_cycles(CLK_MHZ, DEBOUNCE_US);
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be at least 1");
  end
  if (N_KEYS < 1) begin : g_bad_keys
    $error("N_KEYS must be at least 1");
  end
  if (RST_STAGES < 2) begin : g_bad_rst
    $error("RST_STAGES must be at least 2");
  end
  logic [RST_STAGES-1:0] rst_sync_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '1;
    else          rst_sync_q <= {rst_sync_q[RST_STAGES-2:0], 1'b0};
  end
  assign rst_o = rst_sync_q[RST_STAGES-1];
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES     (DB_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_key (
      .clk_i    (clk_i),
      .rst_i    (rst_o),
      .key_i    (keys_i[i]),
      .level_o  (keys_o[i]),
      .press_o  (key_press_o[i]),
      .release_o(key_release_o[i])
    );
  end
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed and random checks of the board input conditioner
module tb_board_input_conditioner;
  localparam int DB = 4;
  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic [1:0] keys_i = 2'b11;
  logic       rst_o;
  logic [1:0] keys_o, key_press_o, key_release_o;
  int n_cmp = 0;
  int n_bad = 0;
  board_input_conditioner #(
    .CLK_MHZ(4), .N_KEYS(2), .DEBOUNCE_US(1), .KEY_ACTIVE_LOW(1'b1), .RST_STAGES(2)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .keys_i       (keys_i),
    .rst_o        (rst_o),
    .keys_o       (keys_o),
    .key_press_o  (key_press_o),
    .key_release_o(key_release_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  // Reference model: a key flips only after DB consecutive synced samples disagree with its level
  logic [6:0] exp_q[$];
  logic [1:0] m_rsync = 2'b11;
  logic [1:0] m_s0 = 2'b11, m_s1 = 2'b11, m_lvl = 2'b00, m_pr = 2'b00, m_rl = 2'b00;
  int         m_run[2] = '{0, 0};
  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_rsync = 2'b11; m_s0 = 2'b11; m_s1 = 2'b11;
      m_lvl = 2'b00; m_pr = 2'b00; m_rl = 2'b00; m_run = '{0, 0};
    end else begin
      if (m_rsync[1]) begin
        m_s0 = 2'b11; m_s1 = 2'b11;
        m_lvl = 2'b00; m_pr = 2'b00; m_rl = 2'b00; m_run = '{0, 0};
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_pr[k] = 1'b0;
          m_rl[k] = 1'b0;
          if ((!m_s1[k]) != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_lvl[k] = !m_lvl[k];
              m_pr[k]  = m_lvl[k];
              m_rl[k]  = !m_lvl[k];
              m_run[k] = 0;
            end
          end else m_run[k] = 0;
        end
        m_s1 = m_s0;
        m_s0 = keys_i;
      end
      m_rsync = {m_rsync[0], 1'b0};
    end
    exp_q.push_back({m_rsync[1], m_lvl, m_pr, m_rl});
  end
  always @(negedge clk_i) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n_i) e = 7'b100_0000;
      chk("sb", {25'd0, rst_o, keys_o, key_press_o, key_release_o}, {25'd0, e});
    end
  end
  initial begin
    // Scenario 1: async assert, release on the 2nd edge
    #2 rst_n_i = 1'b0;
    #1 chk("s1_rst_async", rst_o, 1);
    chk("s1_outs_async", {keys_o, key_press_o, key_release_o}, 0);
    cyc(3);
    chk("s1_rst_held", rst_o, 1);
    #1 rst_n_i = 1'b1;
    cyc(1);
    chk("s1_rst_edge1", rst_o, 1);
    cyc(1);
    chk("s1_rst_edge2", rst_o, 0);
    chk("s1_outs", {keys_o, key_press_o, key_release_o}, 0);
    cyc(3);
    // Scenario 2: clean press on key 0
    #1 keys_i = 2'b10;
    cyc(5);
    chk("s2_before", keys_o, 2'b00);
    cyc(1);
    chk("s2_level", keys_o, 2'b01);
    chk("s2_press", key_press_o, 2'b01);
    cyc(1);
    chk("s2_press_end", key_press_o, 2'b00);
    chk("s2_hold", keys_o, 2'b01);
    #1 keys_i = 2'b11;
    cyc(10);
    chk("s2_released", keys_o, 2'b00);
    // Scenario 3: bounce that reaches count DB-1, then a held fall
    #1 keys_i = 2'b10;
    cyc(3);
    #1 keys_i = 2'b11;
    cyc(1);
    #1 keys_i = 2'b10;
    cyc(5);
    chk("s3_before", keys_o, 2'b00);
    cyc(1);
    chk("s3_level", keys_o, 2'b01);
    chk("s3_press", key_press_o, 2'b01);
    // Scenario 4: simultaneous release of both keys
    #1 keys_i = 2'b00;
    cyc(10);
    chk("s4_both_down", keys_o, 2'b11);
    #1 keys_i = 2'b11;
    cyc(5);
    chk("s4_before", {keys_o, key_release_o}, 4'b1100);
    cyc(1);
    chk("s4_level", keys_o, 2'b00);
    chk("s4_release", key_release_o, 2'b11);
    chk("s4_no_press", key_press_o, 2'b00);
    cyc(1);
    chk("s4_release_end", key_release_o, 2'b00);
    // Scenario 5: reset mid-debounce with key 1 held
    cyc(3);
    #1 keys_i = 2'b01;
    cyc(4);
    #1 rst_n_i = 1'b0;
    #1 chk("s5_rst_async", rst_o, 1);
    chk("s5_outs_clear", {keys_o, key_press_o, key_release_o}, 0);
    cyc(1);
    #1 rst_n_i = 1'b1;
    cyc(1);
    chk("s5_rst_edge1", rst_o, 1);
    cyc(1);
    chk("s5_rst_edge2", rst_o, 0);
    cyc(5);
    chk("s5_before", {keys_o, key_press_o}, 4'b0000);
    cyc(1);
    chk("s5_level", keys_o, 2'b10);
    chk("s5_press", key_press_o, 2'b10);
    // Scenario 6: random bounce, checked by the scoreboard every cycle
    #1 keys_i = 2'b11;
    cyc(10);
    for (int n = 0; n < 400; n++) begin
      cyc(1);
      #1;
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 5) == 0) keys_i[k] = !keys_i[k];
    end
    cyc(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50: system clock frequency in MHz.
REQ-002 SHALL have parameter N_KEYS, default 2: number of board push-buttons, minimum 1.
REQ-003 SHALL have parameter DEBOUNCE_US, default 10000: required stable time per key, in microseconds.
REQ-004 SHALL have parameter KEY_ACTIVE_LOW, default 1: 1 means raw key level 0 is "pressed".
REQ-005 SHALL have parameter RST_STAGES, default 2: reset synchroniser depth, minimum 2.
REQ-006 SHALL have port clk_i, input, 1: single system clock.
REQ-007 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port keys_i, input, N_KEYS: raw asynchronous button levels.
REQ-009 SHALL have port rst_o, output, 1: active-high reset for the game core; asserts asynchronously and deasserts synchronously.
REQ-010 SHALL have port keys_o, output, N_KEYS: debounced level per key, 1 = pressed.
REQ-011 SHALL have port key_press_o, output, N_KEYS: one-cycle pulse when keys_o[i] rises.
REQ-012 SHALL have port key_release_o, output, N_KEYS: one-cycle pulse when keys_o[i] falls.

Function
REQ-013 SHALL define DB_CYCLES = CLK_MHZ*DEBOUNCE_US; elaboration SHALL fail if DB_CYCLES < 1.
REQ-014 SHALL synchronise each keys_i bit through 2 flops, then normalise it to 1 = pressed according to KEY_ACTIVE_LOW.
REQ-015 SHALL keep one counter per key, ceil(log2(DB_CYCLES+1)) bits wide, that never wraps.
REQ-016 While the synced level equals keys_o[i], the counter for key i SHALL be 0.
REQ-017 While the synced level differs from keys_o[i], the counter for key i SHALL increment each cycle.
REQ-018 On the cycle the counter would reach DB_CYCLES, keys_o[i] SHALL toggle and the counter SHALL clear.
REQ-019 Any return to equality (a bounce) before DB_CYCLES is reached SHALL clear the counter; keys_o[i] SHALL stay unchanged, including a bounce at count DB_CYCLES-1.
REQ-020 A clean raw transition held stable SHALL appear on keys_o exactly 2+DB_CYCLES clock edges after the first edge at which it is sampled.
REQ-021 key_press_o[i] and key_release_o[i] SHALL be registered, high for exactly the one cycle in which keys_o[i] holds its new value, and never both high together.
REQ-022 Keys SHALL be fully independent; simultaneous transitions on several keys SHALL each follow REQ-016 to REQ-021 with no interaction.
REQ-023 A key held pressed through reset release SHALL produce keys_o[i]=1 and one key_press_o[i] pulse exactly DB_CYCLES+2 cycles after debounce logic leaves reset.

Reset
REQ-024 rst_n_i low SHALL immediately and asynchronously force rst_o=1, keys_o=0, key_press_o=0, key_release_o=0, all counters to 0, and key sync flops to the inactive raw level.
REQ-025 After rst_n_i rises, rst_o SHALL fall synchronously on the RST_STAGES-th rising clk_i edge.
REQ-026 All debounce logic SHALL be held in reset by the synchronised internal reset, the same signal as rst_o, not by rst_n_i directly.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count with no press or release pulse.

Structure
REQ-028 Package board_pkg SHALL hold the DB_CYCLES derivation function and the counter-width function, shared with game_top timing code.
REQ-029 Per-key logic SHALL be the sub-module key_debounce, with ports clk_i, rst_i, key_i, level_o, press_o, release_o, instantiated N_KEYS times in a generate loop.
REQ-030 The reset synchroniser SHALL live inline in the top module.

Verification
(All scenarios use CLK_MHZ=4, DEBOUNCE_US=1, so DB_CYCLES=4; N_KEYS=2; KEY_ACTIVE_LOW=1.)
REQ-031 Scenario 1: rst_n_i low, then high -> rst_o=1 asynchronously, falling on the 2nd rising edge after release; all outputs 0 throughout.
REQ-032 Scenario 2: keys_i[0] 1->0 held -> keys_o[0]=1 and key_press_o[0] one-cycle pulse 6 edges after first sampling; key 1 unaffected.
REQ-033 Scenario 3: keys_i[0] low for 3 cycles, high for 1, then low held -> no output change until 6 edges after the final fall.
REQ-034 Scenario 4: both keys released in the same cycle from the pressed state -> key_release_o=2'b11 for exactly one cycle, keys_o=2'b00.
REQ-035 Scenario 5: rst_n_i pulsed low while key 1's counter=2 -> outputs clear at once with no pulse; key held low re-presses at DB_CYCLES+2 after rst_o falls.
REQ-036 Scenario 6: random bounce on both keys plus a self-checking reference model -> keys_o never toggles without 4 consecutive stable synced cycles.
